// File: rtl/mips_pkg.sv
// Types and constants shared across the MIPS pipeline stages.
package mips_pkg;

  typedef logic [31:0] word_t;

  localparam int unsigned INSTR_BYTES = 4;
  localparam word_t DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, addresses a synchronous-read instruction memory and presents
// the returned word with its PC to IF/ID, absorbing stalls and execute-stage redirects.
module fetch_unit
  import mips_pkg::*;
#(
  parameter word_t       RESET_PC  = DEFAULT_RESET_PC,
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  stall,
  input  logic  redirect_valid,
  input  word_t redirect_pc,
  output word_t imem_addr,
  input  word_t imem_inst,
  output word_t if_inst,
  output word_t if_pc,
  output word_t if_pc_plus4,
  output logic  if_valid,
  output word_t fetch_count
);

  localparam word_t ADDR_MASK = word_t'((64'd1 << ADDR_BITS) - 64'd1);
  localparam word_t STEP      = word_t'(INSTR_BYTES);

  word_t pc_q, pc_d;
  word_t resp_pc_q, resp_pc_d;
  logic  resp_valid_q, resp_valid_d;
  word_t fetch_count_q, fetch_count_d;

  word_t fetch_addr;
  word_t redirect_target;
  logic  accept;

  always_comb begin
    redirect_target = redirect_pc & ~word_t'(3);

    pc_d          = pc_q;
    resp_pc_d     = resp_pc_q;
    resp_valid_d  = resp_valid_q;
    fetch_addr    = pc_q;

    if_valid      = resp_valid_q & ~redirect_valid;
    accept        = if_valid & ~stall;
    fetch_count_d = fetch_count_q + word_t'(accept);

    if (rst) begin
      fetch_addr = RESET_PC;
    end else if (redirect_valid) begin
      fetch_addr   = redirect_target;
      resp_pc_d    = redirect_target;
      pc_d         = redirect_target + STEP;
      resp_valid_d = 1'b1;
    end else if (stall) begin
      // Re-read the displayed word so imem_inst holds across the stall.
      fetch_addr = resp_pc_q;
    end else begin
      resp_pc_d    = pc_q;
      pc_d         = pc_q + STEP;
      resp_valid_d = 1'b1;
    end

    imem_addr   = (fetch_addr >> 2) & ADDR_MASK;
    if_inst     = imem_inst;
    if_pc       = resp_pc_q;
    if_pc_plus4 = resp_pc_q + STEP;
    fetch_count = fetch_count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      resp_valid_q  <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      resp_pc_q     <= resp_pc_d;
      resp_valid_q  <= resp_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: instruction-stream model plus hand-computed spot checks.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        if_valid;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .ADDR_BITS(10)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_addr     (imem_addr),
    .imem_inst     (imem_inst),
    .if_inst       (if_inst),
    .if_pc         (if_pc),
    .if_pc_plus4   (if_pc_plus4),
    .if_valid      (if_valid),
    .fetch_count   (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: word k holds 0x1000_0000 + k, one-cycle read latency.
  logic [31:0] mem [1024];
  initial for (int k = 0; k < 1024; k++) mem[k] = 32'h1000_0000 + k;
  always @(posedge clk) imem_inst <= mem[imem_addr[9:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: the word on display, whether one is on display, where the sequential stream
  // continues, and how many instructions downstream has taken.
  logic [31:0] m_shown_pc;
  logic        m_shown;
  logic [31:0] m_next_pc;
  logic [31:0] m_taken;

  function automatic logic [31:0] word_of(input logic [31:0] byte_addr);
    return 32'h1000_0000 + ((byte_addr / 4) % 1024);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_shown_pc = 32'h0;
      m_next_pc  = 32'h0;
      m_shown    = 1'b0;
      m_taken    = 32'h0;
    end else begin
      if (m_shown && !redirect_valid && !stall) m_taken = m_taken + 1;
      if (redirect_valid) begin
        m_shown_pc = {redirect_pc[31:2], 2'b00};
        m_next_pc  = m_shown_pc + 4;
        m_shown    = 1'b1;
      end else if (!stall) begin
        m_shown_pc = m_next_pc;
        m_next_pc  = m_next_pc + 4;
        m_shown    = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] want_addr;
    if (rst) want_addr = 32'h0;
    else if (redirect_valid) want_addr = {redirect_pc[31:2], 2'b00};
    else if (stall) want_addr = m_shown_pc;
    else want_addr = m_next_pc;
    check("model if_valid", {31'b0, if_valid}, {31'b0, m_shown && !redirect_valid});
    check("model if_pc", if_pc, m_shown_pc);
    check("model if_pc_plus4", if_pc_plus4, m_shown_pc + 4);
    check("model fetch_count", fetch_count, m_taken);
    check("model imem_addr", imem_addr, (want_addr / 4) % 1024);
    if (m_shown) check("model if_inst", if_inst, word_of(m_shown_pc));
  end

  task automatic cyc(input logic r, input logic s, input logic rv, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    rst            = r;
    stall          = s;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst            = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    cyc(1, 0, 0, 32'h0);
    check("reset if_valid", {31'b0, if_valid}, 32'h0);
    check("reset if_pc", if_pc, 32'h0);
    check("reset if_pc_plus4", if_pc_plus4, 32'h4);
    check("reset fetch_count", fetch_count, 32'h0);
    check("reset imem_addr", imem_addr, 32'h0);

    cyc(0, 0, 0, 32'h0);
    check("first free cycle if_valid", {31'b0, if_valid}, 32'h0);
    cyc(0, 0, 0, 32'h0);
    check("c1 if_pc", if_pc, 32'h0);
    check("c1 if_inst", if_inst, 32'h1000_0000);
    check("c1 if_valid", {31'b0, if_valid}, 32'h1);
    cyc(0, 0, 0, 32'h0);
    check("c2 if_pc", if_pc, 32'h4);

    // Stall for three cycles while pc 8 is shown.
    cyc(0, 1, 0, 32'h0);
    check("stall start if_pc", if_pc, 32'h8);
    cyc(0, 1, 0, 32'h0);
    cyc(0, 1, 0, 32'h0);
    check("stall held if_pc", if_pc, 32'h8);
    check("stall held if_inst", if_inst, 32'h1000_0002);
    check("stall held fetch_count", fetch_count, 32'h2);
    cyc(0, 0, 0, 32'h0);
    check("stall release if_pc", if_pc, 32'h8);
    cyc(0, 0, 0, 32'h0);
    check("after stall if_pc", if_pc, 32'hC);
    check("after stall fetch_count", fetch_count, 32'h3);

    // Redirect to 0x43 while pc 16 is shown.
    cyc(0, 0, 1, 32'h0000_0043);
    check("redirect kill if_valid", {31'b0, if_valid}, 32'h0);
    check("redirect imem_addr", imem_addr, 32'h10);
    cyc(0, 0, 0, 32'h0);
    check("redirect target if_pc", if_pc, 32'h40);
    check("redirect target if_inst", if_inst, 32'h1000_0010);
    check("redirect excludes killed", fetch_count, 32'h4);

    // Redirect and stall together: the redirect wins.
    cyc(0, 1, 1, 32'h0000_0100);
    check("redirect+stall if_pc", if_pc, 32'h44);
    cyc(0, 0, 0, 32'h0);
    check("redirect over stall if_pc", if_pc, 32'h100);
    check("redirect over stall if_inst", if_inst, 32'h1000_0040);
    check("redirect over stall if_valid", {31'b0, if_valid}, 32'h1);

    // Wrap at the top of the address space.
    cyc(0, 0, 1, 32'hFFFF_FFFC);
    check("wrap imem_addr top", imem_addr, 32'h3FF);
    cyc(0, 0, 0, 32'h0);
    check("wrap if_pc", if_pc, 32'hFFFF_FFFC);
    check("wrap if_pc_plus4", if_pc_plus4, 32'h0);
    check("wrap if_inst", if_inst, 32'h1000_03FF);
    check("wrap imem_addr zero", imem_addr, 32'h0);
    cyc(0, 0, 0, 32'h0);
    check("wrap next if_pc", if_pc, 32'h0);
    check("wrap next fetch_count", fetch_count, 32'h7);

    // Reset mid-stream, build a count of 5, then reset during a stall.
    cyc(1, 0, 0, 32'h0);
    cyc(0, 0, 0, 32'h0);
    check("re-reset fetch_count", fetch_count, 32'h0);
    repeat (5) cyc(0, 0, 0, 32'h0);
    cyc(0, 1, 0, 32'h0);
    check("pre-reset if_pc", if_pc, 32'h14);
    check("pre-reset fetch_count", fetch_count, 32'h5);
    cyc(1, 1, 0, 32'h0);
    check("reset in stall imem_addr", imem_addr, 32'h0);
    cyc(0, 0, 0, 32'h0);
    check("post reset if_valid", {31'b0, if_valid}, 32'h0);
    check("post reset fetch_count", fetch_count, 32'h0);
    check("post reset imem_addr", imem_addr, 32'h0);

    // A short mixed tail for the model to follow.
    cyc(0, 0, 0, 32'h0);
    cyc(0, 1, 0, 32'h0);
    cyc(0, 0, 1, 32'h0000_1002);
    cyc(0, 1, 0, 32'h0);
    cyc(0, 0, 0, 32'h0);
    cyc(0, 0, 1, 32'h0000_0ABC);
    cyc(0, 0, 0, 32'h0);
    cyc(0, 0, 0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
